sync_fifo: RTL

//   Single-clock FIFO sitting on the responder side of the FIFO bus: accepts
//   i_wren/i_wrdata/i_rden from the driver and returns o_rddata and the
//   o_full/o_empty/o_alm_full/o_alm_empty status that the monitor samples.

---
 rtl/sync_fifo.sv | 139 +++++++++++++
 1 files changed

// File: rtl/sync_fifo.sv
// -----------------------------------------------------------------------------
// sync_fifo
//   Single-clock FIFO for the responder side of the FIFO bus. Read data is
//   registered (one edge of latency). Status flags are decoded from the
//   registered occupancy count. The overflow and underflow bits are sticky
//   error bits that record rejected requests until the next reset.
//
// Ports
//   clk          in   1                clock, all logic on posedge
//   rstn         in   1                synchronous reset, active-low
//   i_wren       in   1                write request
//   i_wrdata     in   DATA_W           write data, sampled with i_wren
//   i_rden       in   1                read request
//   o_rddata     out  DATA_W           registered read data
//   o_full       out  1                count == DEPTH
//   o_empty      out  1                count == 0
//   o_alm_full   out  1                count >= DEPTH-ALM_FULL_M
//   o_alm_empty  out  1                count <= ALM_EMPTY_M
//   o_count      out  $clog2(DEPTH)+1  current occupancy
//   o_overflow   out  1                sticky: write attempted while full
//   o_underflow  out  1                sticky: read attempted while empty
// -----------------------------------------------------------------------------
module sync_fifo #(
   parameter int DATA_W      = 128,
   parameter int DEPTH       = 16,
   parameter int ALM_FULL_M  = 2,
   parameter int ALM_EMPTY_M = 2
) (
   input  logic                       clk,
   input  logic                       rstn,
   input  logic                       i_wren,
   input  logic [DATA_W-1:0]          i_wrdata,
   input  logic                       i_rden,
   output logic [DATA_W-1:0]          o_rddata,
   output logic                       o_full,
   output logic                       o_empty,
   output logic                       o_alm_full,
   output logic                       o_alm_empty,
   output logic [$clog2(DEPTH):0]     o_count,
   output logic                       o_overflow,
   output logic                       o_underflow
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   // Storage; deliberately not reset so it can map onto plain RAM.
   logic [DATA_W-1:0] mem [DEPTH];

   logic [AW-1:0]     wr_ptr_q,    wr_ptr_d;
   logic [AW-1:0]     rd_ptr_q,    rd_ptr_d;
   logic [CW-1:0]     count_q,     count_d;
   logic [DATA_W-1:0] rddata_q,    rddata_d;
   logic              overflow_q,  overflow_d;
   logic              underflow_q, underflow_d;

   logic              full_s;
   logic              empty_s;
   logic              wr_acc_s;
   logic              rd_acc_s;

   // Status flags decoded directly from the registered count.
   always_comb begin
      full_s  = (count_q == CW'(DEPTH));
      empty_s = (count_q == {CW{1'b0}});
   end

   // Next-state logic for pointers, count, read data and error bits.
   always_comb begin
      // Full gates writes and empty gates reads, so a read and a write can
      // never address the same entry in one cycle and there is no fall-through.
      wr_acc_s    = i_wren & ~full_s;
      rd_acc_s    = i_rden & ~empty_s;

      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      count_d     = count_q;
      rddata_d    = rddata_q;
      overflow_d  = overflow_q  | (i_wren & full_s);
      underflow_d = underflow_q | (i_rden & empty_s);

      // DEPTH is a power of two, so pointer wrap is the natural AW-bit rollover.
      if (wr_acc_s) begin
         wr_ptr_d = wr_ptr_q + AW'(1);
      end else begin
         wr_ptr_d = wr_ptr_q;
      end

      if (rd_acc_s) begin
         rd_ptr_d = rd_ptr_q + AW'(1);
         rddata_d = mem[rd_ptr_q];
      end else begin
         rd_ptr_d = rd_ptr_q;
         rddata_d = rddata_q;
      end

      case ({wr_acc_s, rd_acc_s})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
   end

   // State registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         wr_ptr_q    <= {AW{1'b0}};
         rd_ptr_q    <= {AW{1'b0}};
         count_q     <= {CW{1'b0}};
         rddata_q    <= {DATA_W{1'b0}};
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         rddata_q    <= rddata_d;
         overflow_q  <= overflow_d;
         underflow_q <= underflow_d;
      end
   end

   // Memory write port; requests presented during reset are ignored.
   always_ff @(posedge clk) begin
      if (rstn && wr_acc_s) begin
         mem[wr_ptr_q] <= i_wrdata;
      end
   end

   assign o_rddata    = rddata_q;
   assign o_full      = full_s;
   assign o_empty     = empty_s;
   assign o_alm_full  = (count_q >= CW'(DEPTH - ALM_FULL_M));
   assign o_alm_empty = (count_q <= CW'(ALM_EMPTY_M));
   assign o_count     = count_q;
   assign o_overflow  = overflow_q;
   assign o_underflow = underflow_q;

endmodule
